// File: rtl/subtractor_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : subtractor_pipe                                                |
// | Desc    : Two-stage W-bit subtractor d = x + ~y + 1 on a prefix-carry    |
// |           datapath, valid/ready handshake on both sides.                 |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module subtractor_pipe #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   d,
   output logic         borrow,
   output logic         zero
);

   localparam int LV = $clog2(W);

   logic         r_s1_valid;
   logic         r_s2_valid;
   logic [W-1:0] r_g;
   logic [W-1:0] r_p;
   logic [W-1:0] r_h;
   logic [W:0]   r_d;
   logic         r_borrow;
   logic         r_zero;

   logic         w_s1_en;
   logic         w_s2_en;
   logic [W-1:0] w_yi;
   logic [W-1:0] w_g;
   logic [W-1:0] w_p;
   logic [W-1:0] w_h;
   logic [W-1:0] w_gc;
   logic [W-1:0] w_pc;
   logic [W-1:0] w_s;
   logic         w_c;

   assign w_s2_en  = ~r_s2_valid | out_ready;
   assign w_s1_en  = ~r_s1_valid | w_s2_en;
   assign in_ready = w_s1_en;

   assign w_yi = ~y;
   assign w_p  = x | w_yi;
   assign w_h  = x ^ w_yi;
   // Carry-in of 1 is absorbed into the bit-0 generate.
   assign w_g  = {x[W-1:1] & w_yi[W-1:1], (x[0] & w_yi[0]) | w_p[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_g        <= '0;
         r_p        <= '0;
         r_h        <= '0;
      end else if (w_s1_en) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_g <= w_g;
            r_p <= w_p;
            r_h <= w_h;
         end
      end
   end

   // Kogge-Stone prefix: each level merges groups at distance 2^l.
   always_comb begin
      w_gc = r_g;
      w_pc = r_p;
      for (int l = 0; l < LV; l++) begin
         w_gc = w_gc | (w_pc & (w_gc << (1 << l)));
         w_pc = w_pc & ((w_pc << (1 << l)) | ((W'(1) << (1 << l)) - W'(1)));
      end
   end

   assign w_s = {r_h[W-1:1] ^ w_gc[W-2:0], ~r_h[0]};
   assign w_c = w_gc[W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_d        <= '0;
         r_borrow   <= 1'b0;
         r_zero     <= 1'b0;
      end else if (w_s2_en) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_d      <= {~w_c, w_s};
            r_borrow <= ~w_c;
            r_zero   <= (w_s == '0);
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign d         = r_d;
   assign borrow    = r_borrow;
   assign zero      = r_zero;

endmodule
`default_nettype wire
